// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce / edge-detect conditioning stage.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      CHECK_HIGH  = 2'd1,
      STABLE_HIGH = 2'd2,
      CHECK_LOW   = 2'd3
   } state_t;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_GLITCH_W        = 8;

   // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Signal bundle between the conditioning stage (slave) and its user (master).
interface debounce_edge_detect_if
   import debounce_pkg::*;
#(
   parameter int GLITCH_W = DEFAULT_GLITCH_W
);
   logic                din_raw;
   logic                glitch_clr;
   logic                dout;
   logic                rise;
   logic                fall;
   logic                busy;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output din_raw, glitch_clr,
      input  dout, rise, fall, busy, glitch_cnt
   );

   modport slave (
      input  din_raw, glitch_clr,
      output dout, rise, fall, busy, glitch_cnt
   );
endinterface

// File: rtl/bit_synchronizer.sv
// Plain multi-flop synchroniser for one asynchronous bit; no logic between stages.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], d};
      end
   end

   assign q = chain_reg[STAGES-1];
endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronises a bouncing input, rejects short pulses, and emits a clean level
// with one-cycle rise/fall pulses plus a saturating count of aborted transitions.
module debounce_edge_detect
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int GLITCH_W        = DEFAULT_GLITCH_W
) (
   input logic                    clk,
   input logic                    reset,
   debounce_edge_detect_if.slave  bus
);
   localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   logic                s;
   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [GLITCH_W-1:0] glitch_reg, glitch_next;
   logic                rise_reg, rise_next;
   logic                fall_reg, fall_next;
   logic                aborted;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.din_raw),
      .q     (s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= STABLE_LOW;
         cnt_reg    <= '0;
         glitch_reg <= '0;
         rise_reg   <= 1'b0;
         fall_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         glitch_reg <= glitch_next;
         rise_reg   <= rise_next;
         fall_reg   <= fall_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      aborted    = 1'b0;
      case (state_reg)
         STABLE_LOW: begin
            if (s) begin
               // A one-cycle filter skips the CHECK state entirely.
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next = STABLE_HIGH;
                  rise_next  = 1'b1;
               end else begin
                  state_next = CHECK_HIGH;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         CHECK_HIGH: begin
            if (!s) begin
               state_next = STABLE_LOW;
               cnt_next   = '0;
               aborted    = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = STABLE_HIGH;
               cnt_next   = '0;
               rise_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next = STABLE_LOW;
                  fall_next  = 1'b1;
               end else begin
                  state_next = CHECK_LOW;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         CHECK_LOW: begin
            if (s) begin
               state_next = STABLE_HIGH;
               cnt_next   = '0;
               aborted    = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = STABLE_LOW;
               cnt_next   = '0;
               fall_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = STABLE_LOW;
            cnt_next   = '0;
         end
      endcase

      // Clear takes priority over a coincident abort.
      glitch_next = glitch_reg;
      if (bus.glitch_clr) begin
         glitch_next = '0;
      end else if (aborted && (glitch_reg != GLITCH_MAX)) begin
         glitch_next = glitch_reg + GLITCH_W'(1);
      end
   end

   assign bus.dout       = (state_reg == STABLE_HIGH) || (state_reg == CHECK_LOW);
   assign bus.busy       = (state_reg == CHECK_HIGH) || (state_reg == CHECK_LOW);
   assign bus.rise       = rise_reg;
   assign bus.fall       = fall_reg;
   assign bus.glitch_cnt = glitch_reg;
endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench: a default build (4-cycle filter) and a 1-cycle build share stimulus
// and are compared against a run-length reference model plus directed expectations.
module tb_debounce_edge_detect;
   localparam int SYNC = 2;
   localparam int DC0  = 4;
   localparam int DC1  = 1;
   localparam int GW   = 8;
   localparam int GMAX = 255;

   logic clk = 1'b0;
   logic rst_n;
   logic din_raw;
   logic glitch_clr;

   int n_cmp  = 0;
   int n_fail = 0;

   debounce_edge_detect_if #(.GLITCH_W(GW)) bus0 ();
   debounce_edge_detect_if #(.GLITCH_W(GW)) bus1 ();

   assign bus0.din_raw    = din_raw;
   assign bus0.glitch_clr = glitch_clr;
   assign bus1.din_raw    = din_raw;
   assign bus1.glitch_clr = glitch_clr;

   debounce_edge_detect #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC0), .GLITCH_W(GW)) dut0 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus0)
   );

   debounce_edge_detect #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC1), .GLITCH_W(GW)) dut1 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   logic [11:0] obs0, obs1;
   assign obs0 = {bus0.dout, bus0.rise, bus0.fall, bus0.busy, bus0.glitch_cnt};
   assign obs1 = {bus1.dout, bus1.rise, bus1.fall, bus1.busy, bus1.glitch_cnt};

   // Reference model: s is the raw input delayed SYNC edges; dout flips once the
   // synchronised input has disagreed with it for DEBOUNCE_CYCLES edges in a row.
   bit raw_q[$];
   bit m_s;
   bit m_abort;
   bit m_dout[2];
   bit m_rise[2];
   bit m_fall[2];
   int m_run[2];
   int m_glitch[2];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            raw_q.delete();
            for (int j = 0; j < SYNC; j++) raw_q.push_back(1'b0);
            for (int i = 0; i < 2; i++) begin
               m_dout[i]   = 1'b0;
               m_rise[i]   = 1'b0;
               m_fall[i]   = 1'b0;
               m_run[i]    = 0;
               m_glitch[i] = 0;
            end
         end else begin
            m_s = raw_q.pop_front();
            raw_q.push_back(din_raw);
            for (int i = 0; i < 2; i++) begin
               m_abort   = 1'b0;
               m_rise[i] = 1'b0;
               m_fall[i] = 1'b0;
               if (m_s != m_dout[i]) begin
                  m_run[i]++;
                  if (m_run[i] == ((i == 0) ? DC0 : DC1)) begin
                     m_dout[i] = m_s;
                     m_rise[i] = m_s;
                     m_fall[i] = !m_s;
                     m_run[i]  = 0;
                  end
               end else begin
                  m_abort  = (m_run[i] != 0);
                  m_run[i] = 0;
               end
               if (glitch_clr) m_glitch[i] = 0;
               else if (m_abort && m_glitch[i] < GMAX) m_glitch[i]++;
            end
         end
      end
   end

   function automatic logic [11:0] exp_vec(input int i);
      logic [31:0] g;
      g = m_glitch[i];
      return {m_dout[i], m_rise[i], m_fall[i], m_run[i] != 0, g[7:0]};
   endfunction

   task automatic test_reset();
      din_raw    = 1'b1;
      glitch_clr = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({obs0, obs1} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h/%h required 000/000", obs0, obs1);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus0.dout, bus0.rise, bus0.fall} !== {k >= 6, k == 6, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_d4 edge %0d: got %b%b%b required %b%b0", k,
                     bus0.dout, bus0.rise, bus0.fall, k >= 6, k == 6);
         end
         n_cmp++;
         if ({bus1.dout, bus1.rise, bus1.fall} !== {k >= 3, k == 3, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_d1 edge %0d: got %b%b%b required %b%b0", k,
                     bus1.dout, bus1.rise, bus1.fall, k >= 3, k == 3);
         end
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL reset_model edge %0d: got %h_%h required %h_%h", k, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
      din_raw = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_clean_edges();
      for (int t = 1; t <= 45; t++) begin
         din_raw = (t >= 10 && t < 30);
         @(negedge clk);
         n_cmp++;
         if ({bus0.dout, bus0.rise, bus0.fall} !== {t >= 15 && t < 35, t == 15, t == 35}) begin
            n_fail++;
            $display("FAIL clean_edges edge %0d: got %b%b%b required %b%b%b", t, bus0.dout, bus0.rise,
                     bus0.fall, t >= 15 && t < 35, t == 15, t == 35);
         end
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL clean_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
   endtask

   task automatic test_glitch();
      int busy_cycles;
      busy_cycles = 0;
      glitch_clr = 1'b1;
      @(negedge clk);
      glitch_clr = 1'b0;
      for (int p = 0; p < 300; p++) begin
         for (int t = 1; t <= 8; t++) begin
            din_raw = (t <= 3);
            @(negedge clk);
            if (p == 0 && bus0.busy === 1'b1) busy_cycles++;
            n_cmp++;
            if (bus0.dout !== 1'b0 || bus0.rise !== 1'b0) begin
               n_fail++;
               $display("FAIL glitch_dout pulse %0d: got dout=%b rise=%b required 0 0", p, bus0.dout, bus0.rise);
            end
            n_cmp++;
            if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
               n_fail++;
               $display("FAIL glitch_model pulse %0d: got %h_%h required %h_%h", p, obs0, obs1, exp_vec(0), exp_vec(1));
            end
            if (p == 0 && t == 8) begin
               n_cmp++;
               if (bus0.glitch_cnt !== 8'd1 || busy_cycles != 3) begin
                  n_fail++;
                  $display("FAIL glitch_first: got cnt=%0d busy=%0d required cnt=1 busy=3", bus0.glitch_cnt, busy_cycles);
               end
            end
         end
      end
      n_cmp++;
      if (bus0.glitch_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL glitch_saturate: got %0d required 255", bus0.glitch_cnt);
      end
   endtask

   task automatic test_boundary();
      int rises, falls;
      rises = 0;
      falls = 0;
      glitch_clr = 1'b1;
      @(negedge clk);
      glitch_clr = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         din_raw = (t <= 4);
         @(negedge clk);
         if (bus0.rise === 1'b1) rises++;
         if (bus0.fall === 1'b1) falls++;
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL exact_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
      n_cmp++;
      if (rises != 1 || falls != 1 || bus0.glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL exact_pulse: got rises=%0d falls=%0d cnt=%0d required 1 1 0", rises, falls, bus0.glitch_cnt);
      end
      for (int t = 1; t <= 50; t++) begin
         din_raw = (t % 2 == 1);
         @(negedge clk);
         n_cmp++;
         if ({bus0.dout, bus0.rise, bus0.fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL toggle_dout edge %0d: got %b%b%b required 000", t, bus0.dout, bus0.rise, bus0.fall);
         end
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL toggle_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
      din_raw = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (bus0.glitch_cnt !== 8'd25 || bus0.dout !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_count: got cnt=%0d dout=%b required 25 0", bus0.glitch_cnt, bus0.dout);
      end
   endtask

   task automatic test_reset_mid();
      din_raw = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus0.busy !== 1'b1 || bus0.dout !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_check_entry: got busy=%b dout=%b required 1 0", bus0.busy, bus0.dout);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs0 !== 12'h000) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %h required 000", obs0);
      end
      n_cmp++;
      if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
         n_fail++;
         $display("FAIL mid_reset_model: got %h_%h required %h_%h", obs0, obs1, exp_vec(0), exp_vec(1));
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus0.dout, bus0.rise} !== {k >= 6, k == 6}) begin
            n_fail++;
            $display("FAIL mid_rerelease edge %0d: got %b%b required %b%b", k, bus0.dout, bus0.rise, k >= 6, k == 6);
         end
      end
      din_raw = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_clr_coincident();
      for (int t = 1; t <= 8; t++) begin
         din_raw = (t <= 3);
         @(negedge clk);
      end
      n_cmp++;
      if (bus0.glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL clr_setup: got %0d required 1", bus0.glitch_cnt);
      end
      for (int t = 1; t <= 10; t++) begin
         din_raw    = (t <= 3);
         glitch_clr = (t == 6);
         @(negedge clk);
         if (t == 5) begin
            n_cmp++;
            if (bus0.glitch_cnt !== 8'd1 || bus0.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL clr_before: got cnt=%0d busy=%b required 1 1", bus0.glitch_cnt, bus0.busy);
            end
         end
         if (t == 6) begin
            n_cmp++;
            if (bus0.glitch_cnt !== 8'd0 || bus0.busy !== 1'b0 || bus0.dout !== 1'b0) begin
               n_fail++;
               $display("FAIL clr_wins: got cnt=%0d busy=%b dout=%b required 0 0 0",
                        bus0.glitch_cnt, bus0.busy, bus0.dout);
            end
         end
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL clr_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
      glitch_clr = 1'b0;
   endtask

   task automatic test_d1_follow();
      logic [3:0] h;
      logic       v;
      h = 4'b0000;
      for (int t = 1; t <= 200; t++) begin
         v       = 1'($urandom_range(0, 1));
         h       = {h[2:0], v};
         din_raw = v;
         @(negedge clk);
         n_cmp++;
         if ({bus1.dout, bus1.rise, bus1.fall} !== {h[2], h[2] & ~h[3], ~h[2] & h[3]}) begin
            n_fail++;
            $display("FAIL d1_follow edge %0d: got %b%b%b required %b%b%b", t, bus1.dout, bus1.rise,
                     bus1.fall, h[2], h[2] & ~h[3], ~h[2] & h[3]);
         end
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL d1_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
   endtask

   task automatic test_random();
      int run_left;
      run_left = 0;
      for (int t = 1; t <= 800; t++) begin
         if (run_left == 0) begin
            run_left = int'($urandom_range(1, 7));
            din_raw  = 1'($urandom_range(0, 1));
         end
         run_left--;
         glitch_clr = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         n_cmp++;
         if ({obs0, obs1} !== {exp_vec(0), exp_vec(1)}) begin
            n_fail++;
            $display("FAIL random_model edge %0d: got %h_%h required %h_%h", t, obs0, obs1, exp_vec(0), exp_vec(1));
         end
      end
      glitch_clr = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      din_raw    = 1'b0;
      glitch_clr = 1'b0;
      test_reset();
      test_clean_edges();
      test_glitch();
      test_boundary();
      test_reset_mid();
      test_clr_coincident();
      test_d1_follow();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
